// File: rtl/spi_ram_pkg.sv
// Shared types and default constants for the SPI RAM controller slice.
package spi_ram_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int TX_HOLD_DEF   = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } ram_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port byte memory with a registered read port; contents are never reset.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 2 ** ADDR_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // NOTE: no reset on the storage array so it maps onto RAM macros rather than flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between the SPI slave and a byte memory: address latches,
// write/read execution and a TX hold FSM that keeps read data stable for the slave.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int TX_HOLD   = TX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    logic                 rx_valid_q;
    logic                 accept;
    cmd_e                 cmd;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           rdata;

    ram_state_e           state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [ADDR_SIZE-1:0] wr_addr, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr, rd_addr_d;
    logic                 rd_addr_vld, rd_addr_vld_d;
    logic                 rd_pend, rd_pend_d;
    logic                 rd_err, rd_err_d;
    logic [7:0]           dout_d;
    logic                 cmd_err_d;

    assign accept   = rx_valid && !rx_valid_q;
    assign cmd      = cmd_e'(din[9:8]);
    assign mem_we   = accept && (cmd == WR_DATA);
    assign mem_addr = mem_we ? wr_addr : rd_addr;
    assign tx_valid = (state == TX);

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (din[7:0]),
        .rdata (rdata)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d       = state;
        cnt_d         = cnt;
        wr_addr_d     = wr_addr;
        rd_addr_d     = rd_addr;
        rd_addr_vld_d = rd_addr_vld;
        rd_pend_d     = 1'b0;
        rd_err_d      = 1'b0;
        dout_d        = dout;
        cmd_err_d     = 1'b0;

        if (accept) begin
            case (cmd)
                WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
                WR_DATA: ;
                RD_ADDR: begin
                    rd_addr_d     = din[ADDR_SIZE-1:0];
                    rd_addr_vld_d = 1'b1;
                end
                RD_DATA: begin
                    rd_pend_d     = 1'b1;
                    rd_err_d      = !rd_addr_vld;
                    rd_addr_vld_d = 1'b0;
                end
                default: ;
            endcase
        end

        case (state)
            IDLE: ;
            TX: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The memory read issued in the accept cycle lands one edge later; a pending
        // read (re)starts the hold from either state.
        if (rd_pend) begin
            state_d   = TX;
            cnt_d     = CNT_W'(TX_HOLD - 1);
            dout_d    = rd_err ? 8'h00 : rdata;
            cmd_err_d = rd_err;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            rd_addr_vld <= 1'b0;
            rd_pend     <= 1'b0;
            rd_err      <= 1'b0;
            dout        <= 8'h00;
            cmd_err     <= 1'b0;
        end else begin
            rx_valid_q  <= rx_valid;
            state       <= state_d;
            cnt         <= cnt_d;
            wr_addr     <= wr_addr_d;
            rd_addr     <= rd_addr_d;
            rd_addr_vld <= rd_addr_vld_d;
            rd_pend     <= rd_pend_d;
            rd_err      <= rd_err_d;
            dout        <= dout_d;
            cmd_err     <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: expected read bytes are queued when RD_DATA is sent
// and compared when the controller presents them on dout/tx_valid.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int TX_HOLD = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .TX_HOLD   (TX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: rx_valid high for 'hold' cycles, then low with din driven unknown.
    task automatic frame(input cmd_e c, input logic [7:0] p, input int hold);
        @(negedge clk);
        din      = {c, p};
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        din      = 'x;
    endtask

    // RD_DATA with rx_valid held 'hold' cycles; checks latency, data, error pulse,
    // exact hold length and dout stability.
    task automatic read_check(input string tag, input logic [7:0] d, input logic er,
                              input int hold);
        exp_t e;
        int   held;
        int   n;
        logic stable;
        logic extra_err;
        sb.push_back(exp_t'{data: d, err: er});
        @(negedge clk);
        din      = {RD_DATA, 8'h00};
        rx_valid = 1'b1;
        held     = hold;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            held--;
            if (held <= 0) begin
                rx_valid = 1'b0;
                din      = 'x;
            end
        end
        e = sb.pop_front();
        check({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
        check({tag, " dout"}, 32'(dout), 32'(e.data));
        check({tag, " cmd_err"}, 32'(cmd_err), 32'(e.err));
        n         = 1;
        stable    = 1'b1;
        extra_err = 1'b0;
        for (int i = 0; i < TX_HOLD + 4; i++) begin
            @(negedge clk);
            held--;
            if (held <= 0) begin
                rx_valid = 1'b0;
                din      = 'x;
            end
            if (!tx_valid) break;
            n++;
            if (dout !== e.data) stable = 1'b0;
            if (cmd_err !== 1'b0) extra_err = 1'b1;
        end
        check({tag, " hold_len"}, 32'(n), 32'(TX_HOLD));
        check({tag, " dout_stable"}, 32'(stable), 32'd1);
        check({tag, " err_one_cycle"}, 32'(extra_err), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < TX_HOLD + 4; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
        end
        check({tag, " idle"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        exp_t       e;
        logic       tx_hist [20];
        logic [7:0] dout_hist [20];
        int         run;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        #12;
        check("reset dout", 32'(dout), 32'h00);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WR_DATA before any WR_ADDR lands in mem[0]
        frame(WR_DATA, 8'h11, 1);

        frame(WR_ADDR, 8'h3C, 1);
        frame(WR_DATA, 8'hA5, 1);
        frame(RD_ADDR, 8'h3C, 1);
        read_check("wr_rd", 8'hA5, 1'b0, 1);

        frame(RD_ADDR, 8'h00, 1);
        read_check("mem0_default_waddr", 8'h11, 1'b0, 1);

        // Held rx_valid must execute each command once
        frame(WR_ADDR, 8'h10, 1);
        frame(WR_DATA, 8'h77, 5);
        frame(RD_ADDR, 8'h10, 1);
        read_check("held_77", 8'h77, 1'b0, 5);
        frame(WR_DATA, 8'h88, 5);
        frame(RD_ADDR, 8'h10, 1);
        read_check("held_88", 8'h88, 1'b0, 1);
        read_check("double_rd", 8'h00, 1'b1, 1);

        // Top address
        frame(WR_ADDR, 8'hFF, 1);
        frame(WR_DATA, 8'h5A, 1);
        frame(RD_ADDR, 8'hFF, 1);
        read_check("wrap", 8'h5A, 1'b0, 1);
        frame(RD_ADDR, 8'h00, 1);
        read_check("wrap_mem0", 8'h11, 1'b0, 1);

        // RD_DATA during TX restarts the hold with new data
        frame(WR_ADDR, 8'h20, 1);
        frame(WR_DATA, 8'hC3, 1);
        frame(RD_ADDR, 8'h3C, 1);
        sb.push_back(exp_t'{data: 8'hA5, err: 1'b0});
        @(negedge clk);
        din      = {RD_DATA, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 'x;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            tx_hist[k]   = tx_valid;
            dout_hist[k] = dout;
            case (k)
                1: begin din = {RD_ADDR, 8'h20}; rx_valid = 1'b1; end
                3: begin
                    din      = {RD_DATA, 8'h00};
                    rx_valid = 1'b1;
                    sb.push_back(exp_t'{data: 8'hC3, err: 1'b0});
                end
                2, 4: begin rx_valid = 1'b0; din = 'x; end
                default: ;
            endcase
        end
        e = sb.pop_front();
        check("restart first dout", 32'(dout_hist[1]), 32'(e.data));
        check("restart dout before switch", 32'(dout_hist[4]), 32'(e.data));
        e = sb.pop_front();
        check("restart new dout", 32'(dout_hist[5]), 32'(e.data));
        check("restart dout end", 32'(dout_hist[12]), 32'(e.data));
        run = 0;
        for (int k = 1; k < 20; k++) begin
            if (!tx_hist[k]) break;
            run++;
        end
        check("restart tx_valid run", 32'(run), 32'(4 + TX_HOLD));

        // Reset mid-TX, then release with rx_valid already high
        frame(RD_ADDR, 8'h3C, 1);
        sb.push_back(exp_t'{data: 8'hA5, err: 1'b0});
        @(negedge clk);
        din      = {RD_DATA, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 'x;
        @(negedge clk);
        e = sb.pop_front();
        check("pre_reset tx_valid", 32'(tx_valid), 32'd1);
        check("pre_reset dout", 32'(dout), 32'(e.data));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx_valid", 32'(tx_valid), 32'd0);
        check("async reset dout", 32'(dout), 32'h00);
        check("async reset cmd_err", 32'(cmd_err), 32'd0);
        din      = {RD_DATA, 8'h00};
        rx_valid = 1'b1;
        sb.push_back(exp_t'{data: 8'h00, err: 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        din      = 'x;
        @(negedge clk);
        e = sb.pop_front();
        check("post_reset tx_valid", 32'(tx_valid), 32'd1);
        check("post_reset dout", 32'(dout), 32'(e.data));
        check("post_reset cmd_err", 32'(cmd_err), 32'(e.err));
        wait_idle("post_reset");

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
